// File: rtl/seg_mem_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg_mem_sequencer_if
//  Brief    : Bundles the job-control, loader, processor, segment-memory and
//             dump-stream signals seen by seg_mem_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface seg_mem_sequencer_if #(
    parameter int WIDTH = 24
);
    // job control
    logic             start;
    logic             done;
    logic [2:0]       state;
    // image loader stream
    logic             ld_valid;
    logic [WIDTH-1:0] ld_data;
    logic             ld_ready;
    // processor data port
    logic             cpu_run;
    logic             cpu_done;
    logic             cpu_we_in;
    logic [WIDTH-1:0] cpu_a_in;
    logic [WIDTH-1:0] cpu_wd_in;
    logic             cpu_we_out;
    logic [WIDTH-1:0] cpu_a_out;
    logic [WIDTH-1:0] cpu_wd_out;
    // segmented memory, data-in and data-out segments
    logic             mem_we_in;
    logic [WIDTH-1:0] mem_a_in;
    logic [WIDTH-1:0] mem_wd_in;
    logic             mem_we_out;
    logic [WIDTH-1:0] mem_a_out;
    logic [WIDTH-1:0] mem_wd_out;
    logic [WIDTH-1:0] mem_rd_out;
    // result dump stream
    logic             dp_valid;
    logic [WIDTH-1:0] dp_data;
    logic             dp_ready;

    // sequencer side
    modport slave (
        input  start, ld_valid, ld_data, cpu_done,
        input  cpu_we_in, cpu_a_in, cpu_wd_in,
        input  cpu_we_out, cpu_a_out, cpu_wd_out,
        input  mem_rd_out, dp_ready,
        output done, state, ld_ready, cpu_run,
        output mem_we_in, mem_a_in, mem_wd_in,
        output mem_we_out, mem_a_out, mem_wd_out,
        output dp_valid, dp_data
    );

    // environment side (loader, processor, memory, dump consumer)
    modport master (
        output start, ld_valid, ld_data, cpu_done,
        output cpu_we_in, cpu_a_in, cpu_wd_in,
        output cpu_we_out, cpu_a_out, cpu_wd_out,
        output mem_rd_out, dp_ready,
        input  done, state, ld_ready, cpu_run,
        input  mem_we_in, mem_a_in, mem_wd_in,
        input  mem_we_out, mem_a_out, mem_wd_out,
        input  dp_valid, dp_data
    );
endinterface
`default_nettype wire

// File: rtl/seg_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : seg_mem_sequencer
//  Brief    : Runs one image job over the segmented data memory: loads the
//             input image into the data-in segment, hands both data segments
//             to the processor, then streams the data-out segment out.
//  Revision : 1.0  initial release
// ============================================================================
module seg_mem_sequencer #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 90000
) (
    input wire              clk,
    input wire              rst_n,
    seg_mem_sequencer_if.slave bus
);

    localparam logic [2:0]       c_IDLE  = 3'd0;
    localparam logic [2:0]       c_LOAD  = 3'd1;
    localparam logic [2:0]       c_RUN   = 3'd2;
    localparam logic [2:0]       c_DUMP  = 3'd3;
    localparam logic [2:0]       c_DONE  = 3'd4;

    localparam logic             c_FETCH = 1'b0;
    localparam logic             c_HOLD  = 1'b1;

    localparam logic [WIDTH-1:0] c_ZERO  = '0;
    localparam logic [WIDTH-1:0] c_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_LAST  = WIDTH'(DEPTH - 1);

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_phase;
    logic             r_dp_valid;
    logic [WIDTH-1:0] r_dp_data;

    logic             w_last;
    logic             w_dump_adv;
    logic [WIDTH-1:0] w_dump_addr;

    assign w_last     = (r_cnt == c_LAST);
    // A dump handshake that moves on to another word
    assign w_dump_adv = (r_phase == c_HOLD) && bus.dp_ready && !w_last;
    // The memory answers one cycle after the address, and FETCH lasts a
    // single cycle, so the next word's address is presented already in the
    // handshake cycle; the data is then ready when FETCH samples it.
    assign w_dump_addr = w_dump_adv ? (r_cnt + c_ONE) : r_cnt;

    // Job FSM: state, word pointer and the registered dump stream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_cnt      <= c_ZERO;
            r_phase    <= c_FETCH;
            r_dp_valid <= 1'b0;
            r_dp_data  <= c_ZERO;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (bus.start) begin
                        r_state <= c_LOAD;
                        r_cnt   <= c_ZERO;
                    end
                end
                c_LOAD: begin
                    if (bus.ld_valid) begin
                        if (w_last) begin
                            r_state <= c_RUN;
                            r_cnt   <= c_ZERO;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end
                c_RUN: begin
                    if (bus.cpu_done) begin
                        r_state <= c_DUMP;
                        r_cnt   <= c_ZERO;
                        r_phase <= c_FETCH;
                    end
                end
                c_DUMP: begin
                    if (r_phase == c_FETCH) begin
                        r_dp_data  <= bus.mem_rd_out;
                        r_dp_valid <= 1'b1;
                        r_phase    <= c_HOLD;
                    end else if (bus.dp_ready) begin
                        // dp_valid is always set in HOLD, so this is the handshake
                        r_dp_valid <= 1'b0;
                        r_phase    <= c_FETCH;
                        if (w_last) begin
                            r_state <= c_DONE;
                            r_cnt   <= c_ZERO;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end
                default: begin
                    r_state    <= c_IDLE;
                    r_cnt      <= c_ZERO;
                    r_phase    <= c_FETCH;
                    r_dp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Segment port mux: load engine, processor passthrough or dump engine
    always_comb begin
        bus.mem_we_in  = 1'b0;
        bus.mem_a_in   = c_ZERO;
        bus.mem_wd_in  = c_ZERO;
        bus.mem_we_out = 1'b0;
        bus.mem_a_out  = c_ZERO;
        bus.mem_wd_out = c_ZERO;
        case (r_state)
            c_LOAD: begin
                bus.mem_we_in = bus.ld_valid;
                bus.mem_a_in  = r_cnt;
                bus.mem_wd_in = bus.ld_data;
            end
            c_RUN: begin
                bus.mem_we_in  = bus.cpu_we_in;
                bus.mem_a_in   = bus.cpu_a_in;
                bus.mem_wd_in  = bus.cpu_wd_in;
                bus.mem_we_out = bus.cpu_we_out;
                bus.mem_a_out  = bus.cpu_a_out;
                bus.mem_wd_out = bus.cpu_wd_out;
            end
            c_DUMP: begin
                bus.mem_a_out = w_dump_addr;
            end
            default: begin
            end
        endcase
    end

    // Status and handshake outputs decoded from the registered state
    assign bus.state    = r_state;
    assign bus.done     = (r_state == c_DONE);
    assign bus.ld_ready = (r_state == c_LOAD);
    assign bus.cpu_run  = (r_state == c_RUN);
    assign bus.dp_valid = r_dp_valid;
    assign bus.dp_data  = r_dp_data;

endmodule
`default_nettype wire
